// File: rtl/rr_grant_sequencer_if.sv
// Level req/grant bundle between N requesters and the round-robin grant sequencer.
// The sequencer connects through the slave modport; requesters use master.
interface rr_grant_sequencer_if #(
    parameter int unsigned N = 4
) ();
    localparam int unsigned IdW = $clog2(N);

    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic [IdW-1:0] grant_id;
    logic           busy;
    logic           timeout;
    logic           err_onehot;

    modport master (
        output req,
        input  grant,
        input  grant_id,
        input  busy,
        input  timeout,
        input  err_onehot
    );

    modport slave (
        input  req,
        output grant,
        output grant_id,
        output busy,
        output timeout,
        output err_onehot
    );
endinterface

// File: rtl/rr_grant_sequencer.sv
// Round-robin arbiter for one shared resource: holds grant while the owner requests, revokes
// after MAX_HOLD cycles, and forces GAP all-low cycles between owners.
module rr_grant_sequencer #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned GAP      = 1
) (
    input logic                 clk,
    input logic                 rst,
    rr_grant_sequencer_if.slave bus
);
    localparam int unsigned IdW   = $clog2(N);
    localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
    localparam int unsigned GapW  = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

    state_e         state_q, state_d;
    logic [IdW-1:0] ptr_q, ptr_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IdW-1:0] grant_id_q, grant_id_d;
    logic           busy_q;
    logic           timeout_q, timeout_d;
    logic           err_q;

    logic [N-1:0]   req;
    logic           any_req;
    logic [IdW-1:0] sel;
    logic [IdW-1:0] cand;
    logic [IdW-1:0] next_ptr;
    logic           found;
    logic           arbitrate;
    logic           multi_grant;
    int unsigned    idx;

    assign req     = bus.req;
    assign any_req = |req;

    // First requester at or after ptr, wrapping modulo N.
    always_comb begin
        sel   = '0;
        cand  = '0;
        idx   = 0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx  = (32'(ptr_q) + k) % N;
            cand = IdW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign next_ptr = (grant_id_q == IdW'(N - 1)) ? '0 : grant_id_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        gap_d      = gap_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        timeout_d  = 1'b0;
        arbitrate  = 1'b0;

        case (state_q)
            StIdle: arbitrate = 1'b1;
            StGrant: begin
                // Owner drop is checked first so it wins over a coincident timeout.
                if (!req[grant_id_q]) begin
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    hold_d  = '0;
                    gap_d   = '0;
                    state_d = StGap;
                end else if (hold_q == HoldW'(MAX_HOLD)) begin
                    grant_d   = '0;
                    ptr_d     = next_ptr;
                    hold_d    = '0;
                    gap_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = StGap;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StGap: begin
                // The edge closing the last gap cycle already arbitrates as IDLE would.
                if (gap_q == GapW'(GAP - 1)) begin
                    arbitrate = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (arbitrate) begin
            if (any_req) begin
                grant_d    = {{(N - 1){1'b0}}, 1'b1} << sel;
                grant_id_d = sel;
                hold_d     = HoldW'(1);
                state_d    = StGrant;
            end else begin
                state_d = StIdle;
            end
        end
    end

    assign multi_grant = |(grant_q & (grant_q - 1'b1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            hold_q     <= '0;
            gap_q      <= '0;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            gap_q      <= gap_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            busy_q     <= |grant_d;
            timeout_q  <= timeout_d;
            err_q      <= err_q | multi_grant;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.busy       = busy_q;
    assign bus.timeout    = timeout_q;
    assign bus.err_onehot = err_q;
endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Bench for rr_grant_sequencer (N=4, MAX_HOLD=8, GAP=1): vector table through a scoreboard
// queue, a hand-written async-reset sequence, and req/grant protocol properties.
module tb_rr_grant_sequencer;
    localparam int unsigned N        = 4;
    localparam int unsigned MAX_HOLD = 8;
    localparam int unsigned GAP      = 1;

    typedef struct packed {
        logic [7:0] tag;
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] id;
        logic       busy;
        logic       to;
    } vec_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    rr_grant_sequencer_if #(.N(N)) bus ();

    rr_grant_sequencer #(
        .N(N),
        .MAX_HOLD(MAX_HOLD),
        .GAP(GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_sva
        a_rose: assert property (@(posedge clk) disable iff (!rst)
            $rose(bus.grant[gi]) |-> bus.req[gi])
            else begin
                errors++;
                $display("FAIL sva_rose_without_req[%0d] got req=0 want req=1", gi);
            end
        a_fell: assert property (@(posedge clk) disable iff (!rst)
            $fell(bus.grant[gi]) |-> (bus.grant == '0))
            else begin
                errors++;
                $display("FAIL sva_gap_after_fall[%0d] got grant=%b want grant=0000", gi, bus.grant);
            end
    end

    a_onehot: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(bus.grant) && !bus.err_onehot)
        else begin
            errors++;
            $display("FAIL sva_onehot got grant=%b err=%b want onehot0 and err=0",
                     bus.grant, bus.err_onehot);
        end

    function automatic void add(input logic [7:0] tag, input logic [3:0] r, input logic [3:0] g,
                                input logic [1:0] id, input logic to);
        vec_t v;
        v.tag   = tag;
        v.req   = r;
        v.grant = g;
        v.id    = id;
        v.busy  = |g;
        v.to    = to;
        vecs.push_back(v);
    endfunction

    task automatic check(input vec_t e, input int idx);
        checks++;
        if (bus.grant !== e.grant || bus.grant_id !== e.id || bus.busy !== e.busy ||
            bus.timeout !== e.to || bus.err_onehot !== 1'b0) begin
            errors++;
            $display("FAIL t%0d[%0d] got grant=%b id=%0d busy=%b timeout=%b err=%b want grant=%b id=%0d busy=%b timeout=%b err=0",
                     e.tag, idx, bus.grant, bus.grant_id, bus.busy, bus.timeout, bus.err_onehot,
                     e.grant, e.id, e.busy, e.to);
        end
    endtask

    // Drive one cycle of req, queue its expected outputs, compare after the sampling edge.
    task automatic run_vec(input vec_t v, input int idx);
        bus.req = v.req;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty[%0d] got 0 entries want 1", idx);
        end else begin
            check(exp_q.pop_front(), idx);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got no finish want finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   ow[5];
        vec_t rv;
        vec_t hv;

        rst     = 1'b0;
        bus.req = '0;
        rv      = '{tag: 8'd0, req: 4'b0000, grant: 4'b0000, id: 2'd0, busy: 1'b0, to: 1'b0};
        #2;
        check(rv, 0);
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // All four requesting: owners 0,1,2,3,0, each 8 cycles, then a timeout gap cycle.
        ow = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 8; c++) add(8'd2, 4'b1111, 4'(1 << ow[k]), 2'(ow[k]), 1'b0);
            add(8'd2, 4'b1111, 4'b0000, 2'(ow[k]), 1'b1);
        end
        add(8'd2, 4'b0000, 4'b0000, 2'd0, 1'b0);

        // Single requester 2 for four cycles.
        add(8'd1, 4'b0000, 4'b0000, 2'd0, 1'b0);
        add(8'd1, 4'b0000, 4'b0000, 2'd0, 1'b0);
        for (int c = 0; c < 4; c++) add(8'd1, 4'b0100, 4'b0100, 2'd2, 1'b0);
        add(8'd1, 4'b0000, 4'b0000, 2'd2, 1'b0);
        add(8'd1, 4'b0000, 4'b0000, 2'd2, 1'b0);

        // Owner 1 drops as req[3] rises; other reqs ignored while 3 owns.
        add(8'd3, 4'b0010, 4'b0010, 2'd1, 1'b0);
        add(8'd3, 4'b0010, 4'b0010, 2'd1, 1'b0);
        add(8'd3, 4'b1000, 4'b0000, 2'd1, 1'b0);
        add(8'd3, 4'b1000, 4'b1000, 2'd3, 1'b0);
        add(8'd3, 4'b1001, 4'b1000, 2'd3, 1'b0);
        add(8'd3, 4'b0001, 4'b0000, 2'd3, 1'b0);
        add(8'd3, 4'b0001, 4'b0001, 2'd0, 1'b0);

        // req[0] stuck: revoke at 8 cycles, regrant after one gap; then drop exactly at the limit.
        for (int c = 0; c < 7; c++) add(8'd4, 4'b0001, 4'b0001, 2'd0, 1'b0);
        add(8'd4, 4'b0001, 4'b0000, 2'd0, 1'b1);
        for (int c = 0; c < 8; c++) add(8'd4, 4'b0001, 4'b0001, 2'd0, 1'b0);
        add(8'd4, 4'b0000, 4'b0000, 2'd0, 1'b0);
        add(8'd4, 4'b0000, 4'b0000, 2'd0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Asynchronous reset between edges while requester 2 owns.
        hv = '{tag: 8'd5, req: 4'b0100, grant: 4'b0100, id: 2'd2, busy: 1'b1, to: 1'b0};
        run_vec(hv, 0);
        run_vec(hv, 1);
        #3;
        rst = 1'b0;
        #1;
        rv.tag = 8'd5;
        check(rv, 2);
        bus.req = 4'b0110;
        #1;
        check(rv, 3);
        #2;
        rst = 1'b1;
        hv = '{tag: 8'd5, req: 4'b0110, grant: 4'b0010, id: 2'd1, busy: 1'b1, to: 1'b0};
        run_vec(hv, 4);
        run_vec(hv, 5);
        hv = '{tag: 8'd5, req: 4'b0000, grant: 4'b0000, id: 2'd1, busy: 1'b0, to: 1'b0};
        run_vec(hv, 6);
        run_vec(hv, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
